// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - register offsets and bit positions for the UART FIFO MMIO block
package uart_fifo_pkg;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_RXDATA = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_e;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_NEMPT = 3;
    localparam int ST_RX_FULL  = 4;
    localparam int ST_OVERRUN  = 5;
    localparam int ST_IRQ      = 6;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    localparam int CTRL_TX_FLUSH = 8;
    localparam int CTRL_RX_FLUSH = 9;
    localparam int CTRL_OVR_CLR  = 10;

    localparam int RXDATA_EMPTY_BIT = 31;

endpackage

// File: rtl/uart_fifo_mmio_if.sv
// rtl/uart_fifo_mmio_if.sv - CPU peripheral bus bundle for the UART FIFO MMIO block
interface uart_fifo_mmio_if;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] mmio_rdata;

    modport master (
        output bus_valid, bus_write, bus_addr, bus_wdata,
        input  bus_ready, mmio_rdata
    );

    modport slave (
        input  bus_valid, bus_write, bus_addr, bus_wdata,
        output bus_ready, mmio_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with flush; a push while full is taken only alongside a pop
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_mmio.sv
// rtl/uart_fifo_mmio.sv - MMIO UART TX/RX buffer with overrun, flush and CTRL/STATUS registers
// Optional level interrupt (enables, STATUS bit6, irq) built only with UART_FIFO_IRQ_EN defined.
module uart_fifo_mmio
    import uart_fifo_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_fifo_mmio_if.slave   bus,
    output logic              req_valid,
    output logic [DATA_W-1:0] req_data,
    input  logic              req_accept,
    input  logic              tx_busy,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    reg_sel_e          sel;
    logic              wr_acc, rd_acc, tx_wr, tx_push, ctrl_wr, rx_pop;
    logic              tx_flush, rx_flush, ovr_clr, ovr_set, ovr;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [TX_AW:0]    tx_count;
    logic [RX_AW:0]    rx_count;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [2:0]        ie;
    logic [31:0]       status;

    wire unused_bus_bits = &{1'b0, bus.bus_addr, bus.bus_wdata};

    assign sel      = reg_sel_e'(bus.bus_addr[3:2]);
    assign wr_acc   = bus.bus_valid && bus.bus_write;
    assign rd_acc   = bus.bus_valid && !bus.bus_write;
    assign tx_wr    = wr_acc && (sel == REG_TXDATA);
    assign bus.bus_ready = !(tx_wr && tx_full);
    assign tx_push  = tx_wr && !tx_full;
    assign ctrl_wr  = wr_acc && (sel == REG_CTRL);
    assign tx_flush = ctrl_wr && bus.bus_wdata[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr && bus.bus_wdata[CTRL_RX_FLUSH];
    assign ovr_clr  = ctrl_wr && bus.bus_wdata[CTRL_OVR_CLR];
    assign rx_pop   = rd_acc && (sel == REG_RXDATA) && !rx_empty;
    // A full RX FIFO still takes the character when the CPU pops in the same cycle.
    assign ovr_set  = rx_valid && rx_full && !rx_pop;

    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(req_accept), .flush(tx_flush),
        .wdata(bus.bus_wdata[DATA_W-1:0]), .head(tx_head), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .flush(rx_flush),
        .wdata(rx_data), .head(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    assign req_valid = !tx_empty;
    assign req_data  = tx_head;

    always_ff @(posedge clk) begin
        if (rst)          ovr <= 1'b0;
        else if (ovr_set) ovr <= 1'b1;
        else if (ovr_clr) ovr <= 1'b0;
    end

`ifdef UART_FIFO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ie  <= 3'b000;
            irq <= 1'b0;
        end else begin
            if (ctrl_wr) ie <= bus.bus_wdata[2:0];
            irq <= |({ovr, !rx_empty, tx_empty} & ie);
        end
    end
`else
    assign ie  = 3'b000;
    assign irq = 1'b0;
`endif

    always_comb begin
        status = '0;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_NEMPT] = !rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVERRUN]  = ovr;
        status[ST_IRQ]      = irq;
        status[ST_TX_CNT_LSB +: 8] = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
    end

    always_comb begin
        bus.mmio_rdata = '0;
        case (sel)
            REG_STATUS: bus.mmio_rdata = status;
            REG_RXDATA: begin
                bus.mmio_rdata[7:0]              = rx_empty ? 8'h00 : 8'(rx_head);
                bus.mmio_rdata[RXDATA_EMPTY_BIT] = rx_empty;
            end
            REG_CTRL:   bus.mmio_rdata[2:0] = ie;
            default:    bus.mmio_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb/tb_uart_fifo_mmio.sv - directed self-checking bench for uart_fifo_mmio
module tb_uart_fifo_mmio;

`ifdef UART_FIFO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_accept;
    logic       tx_busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       irq;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [31:0] rv;

    uart_fifo_mmio_if bus_if ();

    uart_fifo_mmio #(.TX_DEPTH(16), .RX_DEPTH(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .req_valid(req_valid), .req_data(req_data), .req_accept(req_accept),
        .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.bus_valid = 1'b1; bus_if.bus_write = 1'b1;
        bus_if.bus_addr = a;     bus_if.bus_wdata = d;
        cyc();
        bus_if.bus_valid = 1'b0; bus_if.bus_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.bus_valid = 1'b1; bus_if.bus_write = 1'b0; bus_if.bus_addr = a;
        #1 d = bus_if.mmio_rdata;
        cyc();
        bus_if.bus_valid = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        bus_if.bus_addr = 32'h4;
        #1 check(tag, bus_if.mmio_rdata, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        cyc();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_accept = 1'b0; tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0;
        bus_if.bus_valid = 1'b0; bus_if.bus_write = 1'b0;
        bus_if.bus_addr = '0;    bus_if.bus_wdata = '0;
        repeat (2) cyc();
        rst = 1'b0;

        // reset state
        #1 check("rst_req_valid", {31'b0, req_valid}, 32'h0);
        check("rst_bus_ready", {31'b0, bus_if.bus_ready}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_rdata0", bus_if.mmio_rdata, 32'h0);
        chk_status("rst_status", 32'h0000_0002);
        rd(32'h8, rv); check("rst_rxdata", rv, 32'h8000_0000);

        // single TX write with tx_busy reflected
        wr(32'h0, 32'h41);
        check("tx1_valid", {31'b0, req_valid}, 32'h1);
        check("tx1_data", {24'b0, req_data}, 32'h41);
        tx_busy = 1'b1;
        chk_status("tx1_status", 32'h0000_0101);
        tx_busy = 1'b0;
        req_accept = 1'b1; cyc(); req_accept = 1'b0;
        check("tx1_drained", {31'b0, req_valid}, 32'h0);

        // fill TX, stall 17th write, then drain across pointer wrap
        for (int i = 0; i < 16; i++) wr(32'h0, 32'hA0 + i);
        chk_status("tx_full_status", 32'h0000_1004);
        bus_if.bus_valid = 1'b1; bus_if.bus_write = 1'b1;
        bus_if.bus_addr = 32'h0; bus_if.bus_wdata = 32'hB0;
        #1 check("tx17_stall", {31'b0, bus_if.bus_ready}, 32'h0);
        cyc();
        check("tx17_head", {24'b0, req_data}, 32'hA0);
        req_accept = 1'b1;
        #1 check("tx17_no_bypass", {31'b0, bus_if.bus_ready}, 32'h0);
        cyc();
        req_accept = 1'b0;
        #1 check("tx17_ready", {31'b0, bus_if.bus_ready}, 32'h1);
        cyc();
        bus_if.bus_valid = 1'b0; bus_if.bus_write = 1'b0;
        chk_status("tx17_status", 32'h0000_1004);
        for (int i = 0; i < 16; i++) begin
            #1 check("tx_order", {24'b0, req_data}, (i < 15) ? 32'hA1 + i : 32'hB0);
            req_accept = 1'b1; cyc(); req_accept = 1'b0;
        end
        check("tx_empty_end", {31'b0, req_valid}, 32'h0);

        // RX ordering and empty read
        rx_pulse(8'h11); rx_pulse(8'h22); rx_pulse(8'h33);
        chk_status("rx3_status", 32'h0003_000A);
        rd(32'h8, rv); check("rx_rd0", rv, 32'h11);
        rd(32'h8, rv); check("rx_rd1", rv, 32'h22);
        rd(32'h8, rv); check("rx_rd2", rv, 32'h33);
        rd(32'h8, rv); check("rx_rd_empty", rv, 32'h8000_0000);
        chk_status("rx_drained_status", 32'h0000_0002);

        // RX overrun, clear, full with same-cycle pop and push
        for (int i = 0; i < 16; i++) rx_pulse(8'h40 + 8'(i));
        chk_status("rx_full_status", 32'h0010_001A);
        rx_pulse(8'hEE);
        chk_status("rx_overrun", 32'h0010_003A);
        wr(32'hC, 32'h400);
        chk_status("ovr_clear", 32'h0010_001A);
        rx_valid = 1'b1; rx_data = 8'h77;
        bus_if.bus_valid = 1'b1; bus_if.bus_write = 1'b0; bus_if.bus_addr = 32'h8;
        #1 check("rx_full_pop_data", bus_if.mmio_rdata, 32'h40);
        cyc();
        rx_valid = 1'b0; bus_if.bus_valid = 1'b0;
        chk_status("rx_full_pop_push", 32'h0010_001A);
        for (int i = 0; i < 15; i++) begin
            rd(32'h8, rv); check("rx_wrap_order", rv, 32'h41 + i);
        end
        rd(32'h8, rv); check("rx_last", rv, 32'h77);
        chk_status("rx_empty_again", 32'h0000_0002);

        // level interrupt on rx_ie
        wr(32'hC, 32'h2);
        rd(32'hC, rv); check("ctrl_readback", rv, IRQ_ON ? 32'h2 : 32'h0);
        rx_pulse(8'h55);
        check("irq_n1", {31'b0, irq}, 32'h0);
        cyc();
        check("irq_n2", {31'b0, irq}, {31'b0, IRQ_ON});
        chk_status("irq_status", IRQ_ON ? 32'h0001_004A : 32'h0001_000A);
        rd(32'h8, rv); check("irq_rx_data", rv, 32'h55);
        check("irq_hold", {31'b0, irq}, {31'b0, IRQ_ON});
        cyc();
        check("irq_fall", {31'b0, irq}, 32'h0);
        wr(32'hC, 32'h0);

        // TX flush wins over same-cycle accept
        for (int i = 1; i <= 5; i++) wr(32'h0, i);
        chk_status("tx5_status", 32'h0000_0500);
        req_accept = 1'b1;
        wr(32'hC, 32'h100);
        req_accept = 1'b0;
        check("flush_req_valid", {31'b0, req_valid}, 32'h0);
        chk_status("flush_status", 32'h0000_0002);

        // reset mid-traffic
        for (int i = 0; i < 3; i++) wr(32'h0, 32'h60 + i);
        rx_pulse(8'h01); rx_pulse(8'h02);
        wr(32'hC, 32'h7);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        bus_if.bus_valid = 1'b1; bus_if.bus_write = 1'b1;
        bus_if.bus_addr = 32'h0; bus_if.bus_wdata = 32'h5A;
        cyc();
        rst = 1'b0; rx_valid = 1'b0;
        bus_if.bus_valid = 1'b0; bus_if.bus_write = 1'b0;
        #1 check("rst2_req_valid", {31'b0, req_valid}, 32'h0);
        check("rst2_irq", {31'b0, irq}, 32'h0);
        check("rst2_bus_ready", {31'b0, bus_if.bus_ready}, 32'h1);
        check("rst2_rdata0", bus_if.mmio_rdata, 32'h0);
        chk_status("rst2_status", 32'h0000_0002);
        rd(32'hC, rv); check("rst2_ctrl", rv, 32'h0);
        rd(32'h8, rv); check("rst2_rxdata", rv, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_fifo_mmio.md
# uart_fifo_mmio

Memory-mapped UART buffer block with both directions: a TX FIFO feeding the UART transmitter request interface and an RX FIFO filled by the UART receiver. It sits on the CPU peripheral bus, next to the UART TX/RX shift engines. It is the parametrised successor to the single-direction TX-only MMIO front end. New over that front end: RX buffering, overrun detection, flush controls and an optional level interrupt.

## Interface
- `TX_DEPTH`, 16: TX FIFO entries. Power of 2, range 2..128.
- `RX_DEPTH`, 16: RX FIFO entries. Power of 2, range 2..128.
- `DATA_W`, 8: character width, 5..8 bits.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bus_valid` in 1: access strobe. The master asserts it for one accepted cycle per access.
- `bus_write` in 1: 1 means write, 0 means read.
- `bus_addr` in 32: only bits [3:2] are decoded.
- `bus_wdata` in 32: write data.
- `bus_ready` out 1: access accepted this cycle.
- `mmio_rdata` out 32: combinational read data for the current `bus_addr`.
- `req_valid` out 1: TX FIFO is not empty.
- `req_data` out DATA_W: TX FIFO head entry (first-word fall-through).
- `req_accept` in 1: the TX engine takes the head entry.
- `tx_busy` in 1: TX engine is shifting. Status only.
- `rx_valid` in 1: one-cycle pulse, a received character is present.
- `rx_data` in DATA_W: the received character.
- `irq` out 1: level interrupt, registered.

## Operation
Register map, selected by `addr[3:2]`:
- 0 TXDATA (write): pushes `wdata[DATA_W-1:0]`. Reads return 0.
- 1 STATUS (read-only):
  - bit0: `tx_busy`
  - bit1: tx_empty
  - bit2: tx_full
  - bit3: rx_nonempty
  - bit4: rx_full
  - bit5: overrun (sticky)
  - bit6: irq
  - [15:8]: tx_count
  - [23:16]: rx_count
  - other bits: 0
- 2 RXDATA (read):
  - Returns `{rx_empty, 23'b0, head}`, with head zero-extended to 8 bits.
  - A read while not empty pops one entry.
  - A read while empty returns 0x8000_0000 and has no side effect.
- 3 CTRL:
  - bits [2:0] are R/W enables: tx_empty_ie, rx_ie, ovr_ie.
  - Write-1 action bits, which read back 0: bit8 flushes TX, bit9 flushes RX, bit10 clears overrun.

Bus handshake:
- `bus_ready` is 0 only for a TXDATA write while tx_full. It is 1 otherwise.
- The block does not stall on `tx_busy`.
- Writes to STATUS and RXDATA are ignored.

TX FIFO:
- Push happens on `write_fire`, which is a TXDATA write with `bus_ready` high.
- Pop happens when `req_accept` is high and the FIFO is not empty. `req_accept` while empty is ignored.
- A push and a pop in the same cycle leave the count unchanged.
- When full, a push is refused even if a pop happens in the same cycle. There is no bypass.

RX FIFO:
- Push on `rx_valid`. Pop on an RXDATA read.
- `rx_valid` while full: the character is dropped, the FIFO and pointers are unchanged, and overrun is set.
- Exception: if full and popped in the same cycle, the push is accepted and overrun is not set.

Flush:
- Resets that FIFO's pointers and count in the cycle after the write.
- Flush takes priority over a same-cycle push or pop on that FIFO.

Overrun:
- Clear and set in the same cycle leaves overrun set.

Pointers and counts:
- Pointers are AW bits and wrap modulo depth.
- Counts are AW+1 bits, zero-extended into the 8-bit STATUS fields.

## Timing
Reset values:
- `req_valid` = 0, `bus_ready` = 1, `irq` = 0, `mmio_rdata` = 0 for addr 0.
- FIFOs empty, overrun = 0, enables = 0.
- Reset mid-traffic discards all contents on the next edge.

Latency:
- TXDATA write at edge N: `req_valid` and `req_data` are valid after edge N.
- `rx_valid` at edge N: visible in STATUS and RXDATA after N.
- An RXDATA pop returns the old head combinationally in the same cycle. The next head is visible after the edge.
- `irq` is registered, one cycle after the condition: `irq <= |({ovr, rx_nonempty, tx_empty} & enables)`.

## Configuration
- `UART_FIFO_IRQ_EN` defined: the enable bits, STATUS bit6 and the `irq` register are implemented as above.
- `UART_FIFO_IRQ_EN` undefined: `irq` is tied 0, CTRL[2:0] read 0 and ignore writes, and STATUS bit6 reads 0. FIFOs, overrun and flush are unchanged.

## Structure
- Package `uart_fifo_pkg` holds:
  - register offsets (TXDATA, STATUS, RXDATA, CTRL)
  - STATUS and CTRL bit positions
  - the RXDATA empty-flag bit index
- Sub-module `sync_fifo` (params DEPTH, WIDTH) provides push, pop, flush, head, count, full and empty. It is instantiated once for TX and once for RX.
- The top level holds the decode, overrun, CTRL and irq logic.

## Test plan
- Reset, then write TXDATA 0x41 -> `req_valid` = 1 next cycle, `req_data` = 0x41, STATUS[15:8] = 1.
- 16 TX writes with no accepts (depth 16) -> STATUS bit2 = 1. The 17th write sees `bus_ready` = 0 until one `req_accept`, then is accepted. Data order is preserved across pointer wrap.
- 3 `rx_valid` pulses (0x11, 0x22, 0x33) -> RXDATA reads return 0x11, 0x22, 0x33. A fourth read returns 0x8000_0000 and rx_count stays 0.
- Fill RX to 16, then 1 more `rx_valid` -> overrun = 1 and the count stays 16. Write CTRL bit10 -> overrun = 0. Full plus same-cycle pop and push -> no overrun.
- CTRL = 0x2, one `rx_valid` -> `irq` rises 2 cycles after the pulse. Drain RX -> `irq` falls one cycle after the pop edge. Without the macro, `irq` stays 0.
- TX holding 5 entries, write CTRL bit8 together with a `req_accept` -> tx_count = 0 and `req_valid` = 0. Assert `rst` mid-traffic -> all reset values restored.
